// File: rtl/vc_fifo_bank_pkg.sv
// Shared constants and helpers for the multi-virtual-channel FIFO bank.
package vc_fifo_bank_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_VC_DEF = 2;
  localparam int VC_W_DEF   = 1;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;
  localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

  // Low bit of slice idx inside a vector packed from equal-width fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/vc_fifo_bank_if.sv
// Write port and per-channel read/look-ahead bus of the FIFO bank.
interface vc_fifo_bank_if
  import vc_fifo_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int VC_W   = VC_W_DEF
);
  logic                     wr_en;
  logic [VC_W-1:0]          wr_vc;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_VC-1:0]        rd_en;
  logic [NUM_VC*DATA_W-1:0] rd_data;
  logic [NUM_VC-1:0]        rd_valid;
  logic [NUM_VC*DATA_W-1:0] head_data;

  modport master (
    output wr_en, wr_vc, wr_data, rd_en,
    input  rd_data, rd_valid, head_data
  );

  modport slave (
    input  wr_en, wr_vc, wr_data, rd_en,
    output rd_data, rd_valid, head_data
  );
endinterface

// File: rtl/vc_fifo_bank_channel.sv
// Single circular FIFO: occupancy count, threshold flags, sticky errors and
// a one-cycle registered read port with a combinational look-ahead head.
module vc_fifo_channel
  import vc_fifo_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err,
  output logic              udf_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r, ovf_r, udf_r;

  logic              full_s, empty_s, rd_ok_s, wr_ok_s, ovf_ev_s, udf_ev_s;
  logic [CNT_W:0]    af_sum_s;

  // Accept/reject decisions, all judged on the pre-edge occupancy.
  always_comb begin
    full_s   = (count_r == DEPTH_C);
    empty_s  = (count_r == {CNT_W{1'b0}});
    rd_ok_s  = rd_en && !empty_s;
    wr_ok_s  = wr_en && (!full_s || rd_ok_s);
    ovf_ev_s = wr_en && full_s && !rd_ok_s;
    udf_ev_s = rd_en && empty_s;
    // count + margin >= DEPTH also covers margins larger than DEPTH.
    af_sum_s = {1'b0, count_r} + {1'b0, af_thresh};
  end

  // Payload storage; contents are never cleared, empty masks stale data.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, read register and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset || !init) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r  <= rd_ptr_r + ADDR_W'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      rd_valid_r <= rd_ok_s;
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      ovf_r <= ovf_ev_s ? 1'b1 : (err_clr ? 1'b0 : ovf_r);
      udf_r <= udf_ev_s ? 1'b1 : (err_clr ? 1'b0 : udf_r);
    end
  end

  assign rd_data      = rd_data_r;
  assign rd_valid     = rd_valid_r;
  assign head_data    = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (af_sum_s >= {1'b0, DEPTH_C}) && !full_s;
  assign almost_empty = (count_r <= ae_thresh) && !empty_s;
  assign count        = count_r;
  assign ovf_err      = ovf_r;
  assign udf_err      = udf_r;
endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent FIFOs behind one VC-steered write port; the top
// level only demuxes the write and packs the per-channel vectors.
module vc_fifo_bank
  import vc_fifo_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int VC_W   = VC_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  vc_fifo_bank_if.slave              bus,
  input  logic [NUM_VC*(ADDR_W+1)-1:0] af_thresh,
  input  logic [NUM_VC*(ADDR_W+1)-1:0] ae_thresh,
  input  logic [NUM_VC-1:0]          err_clr,
  output logic [NUM_VC-1:0]          full,
  output logic [NUM_VC-1:0]          empty,
  output logic [NUM_VC-1:0]          almost_full,
  output logic [NUM_VC-1:0]          almost_empty,
  output logic [NUM_VC*(ADDR_W+1)-1:0] count,
  output logic [NUM_VC-1:0]          ovf_err,
  output logic [NUM_VC-1:0]          udf_err
);
  localparam int CNT_W = ADDR_W + 1;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic wr_sel_s;

    // Out-of-range wr_vc values match no channel and are silently dropped.
    assign wr_sel_s = bus.wr_en && (bus.wr_vc == VC_W'(v));

    vc_fifo_channel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .wr_en        (wr_sel_s),
      .wr_data      (bus.wr_data),
      .rd_en        (bus.rd_en[v]),
      .af_thresh    (af_thresh[slice_lo(v, CNT_W) +: CNT_W]),
      .ae_thresh    (ae_thresh[slice_lo(v, CNT_W) +: CNT_W]),
      .err_clr      (err_clr[v]),
      .rd_data      (bus.rd_data[slice_lo(v, DATA_W) +: DATA_W]),
      .rd_valid     (bus.rd_valid[v]),
      .head_data    (bus.head_data[slice_lo(v, DATA_W) +: DATA_W]),
      .full         (full[v]),
      .empty        (empty[v]),
      .almost_full  (almost_full[v]),
      .almost_empty (almost_empty[v]),
      .count        (count[slice_lo(v, CNT_W) +: CNT_W]),
      .ovf_err      (ovf_err[v]),
      .udf_err      (udf_err[v])
    );
  end
endmodule

// File: tb/tb_vc_fifo_bank.sv
// Bench for vc_fifo_bank: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vc_fifo_bank;
  localparam int DW = 6;
  localparam int AW = 3;
  localparam int NV = 2;
  localparam int DEPTH = 8;
  localparam int CW = AW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, init;
  logic [NV*CW-1:0]  af_thresh, ae_thresh;
  logic [NV-1:0]     err_clr;
  logic [NV-1:0]     full, empty, almost_full, almost_empty, ovf_err, udf_err;
  logic [NV*CW-1:0]  count;

  vc_fifo_bank_if bus ();

  vc_fifo_bank dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .bus          (bus),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .err_clr      (err_clr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel plus the observable registers.
  logic [DW-1:0] mq [NV][$];
  logic [DW-1:0] m_rd_data [NV];
  bit            m_rd_valid [NV];
  bit            m_ovf [NV];
  bit            m_udf [NV];
  bit            model_live = 1'b0;

  always @(posedge clk) begin
    if (!reset || !init) begin
      for (int v = 0; v < NV; v++) begin
        mq[v].delete();
        m_rd_data[v] = '0;
        m_rd_valid[v] = 1'b0;
        m_ovf[v] = 1'b0;
        m_udf[v] = 1'b0;
      end
      model_live = 1'b1;
    end else begin
      for (int v = 0; v < NV; v++) begin
        int sz;
        bit rd, wr, ov, ud;
        sz = mq[v].size();
        rd = bus.rd_en[v] && (sz > 0);
        wr = bus.wr_en && (int'(bus.wr_vc) == v);
        ov = wr && (sz == DEPTH) && !rd;
        ud = bus.rd_en[v] && (sz == 0);
        m_rd_valid[v] = rd;
        if (rd) m_rd_data[v] = mq[v].pop_front();
        if (wr && !ov) mq[v].push_back(bus.wr_data);
        if (ov) m_ovf[v] = 1'b1;
        else if (err_clr[v]) m_ovf[v] = 1'b0;
        if (ud) m_udf[v] = 1'b1;
        else if (err_clr[v]) m_udf[v] = 1'b0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      logic [NV*CW-1:0] e_cnt;
      logic [NV*DW-1:0] e_head, e_rdd;
      logic [NV-1:0]    e_full, e_empty, e_af, e_ae, e_rdv, e_ovf, e_udf;
      for (int v = 0; v < NV; v++) begin
        int c;
        c = mq[v].size();
        e_cnt[v*CW +: CW] = CW'(c);
        e_full[v]  = (c == DEPTH);
        e_empty[v] = (c == 0);
        e_af[v]    = (c >= DEPTH - int'(af_thresh[v*CW +: CW])) && (c != DEPTH);
        e_ae[v]    = (c <= int'(ae_thresh[v*CW +: CW])) && (c != 0);
        e_head[v*DW +: DW] = (c > 0) ? mq[v][0] : '0;
        e_rdd[v*DW +: DW]  = m_rd_data[v];
        e_rdv[v] = m_rd_valid[v];
        e_ovf[v] = m_ovf[v];
        e_udf[v] = m_udf[v];
      end
      cmp("model count", 64'(count), 64'(e_cnt));
      cmp("model full", 64'(full), 64'(e_full));
      cmp("model empty", 64'(empty), 64'(e_empty));
      cmp("model almost_full", 64'(almost_full), 64'(e_af));
      cmp("model almost_empty", 64'(almost_empty), 64'(e_ae));
      cmp("model head_data", 64'(bus.head_data), 64'(e_head));
      cmp("model rd_data", 64'(bus.rd_data), 64'(e_rdd));
      cmp("model rd_valid", 64'(bus.rd_valid), 64'(e_rdv));
      cmp("model ovf_err", 64'(ovf_err), 64'(e_ovf));
      cmp("model udf_err", 64'(udf_err), 64'(e_udf));
    end
  end

  // Inputs change just after the falling edge, clear of both compare points.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0;
    bus.rd_en = '0;
    err_clr = '0;
    init = 1'b1;
  endtask

  task automatic wr(input int vc, input logic [DW-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_vc = 1'(vc);
    bus.wr_data = d;
  endtask

  initial begin
    reset = 1'b0;
    init = 1'b1;
    af_thresh = '0;
    ae_thresh = '0;
    bus.wr_vc = '0;
    bus.wr_data = '0;
    idle();

    // Reset state
    tick(); tick();
    reset = 1'b1;
    tick();
    cmp("rst empty", 64'(empty), 64'h3);
    cmp("rst full", 64'(full), 64'h0);
    cmp("rst count", 64'(count), 64'h0);
    cmp("rst errors", 64'({ovf_err, udf_err}), 64'h0);
    cmp("rst rd_valid", 64'(bus.rd_valid), 64'h0);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) begin wr(0, DW'(i)); tick(); end
    cmp("fill full0", 64'(full[0]), 64'h1);
    cmp("fill count0", 64'(count[3:0]), 64'h8);
    wr(0, 6'h09); tick();
    cmp("ovf flag", 64'(ovf_err[0]), 64'h1);
    cmp("ovf count0", 64'(count[3:0]), 64'h8);
    idle();
    bus.rd_en = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      tick();
      cmp("drain rd_data0", 64'(bus.rd_data[5:0]), 64'(i));
      cmp("drain rd_valid0", 64'(bus.rd_valid[0]), 64'h1);
    end
    idle(); tick();
    cmp("drain empty0", 64'(empty[0]), 64'h1);
    cmp("drain rd_valid idle", 64'(bus.rd_valid[0]), 64'h0);
    err_clr = 2'b01; tick(); idle();
    cmp("ovf cleared", 64'(ovf_err[0]), 64'h0);

    // Write into a full channel alongside a read
    for (int i = 1; i <= 8; i++) begin wr(0, DW'(i)); tick(); end
    wr(0, 6'h2A); bus.rd_en = 2'b01; tick();
    cmp("full wr+rd count0", 64'(count[3:0]), 64'h8);
    cmp("full wr+rd rd_data0", 64'(bus.rd_data[5:0]), 64'h01);
    cmp("full wr+rd no ovf", 64'(ovf_err[0]), 64'h0);
    bus.wr_en = 1'b0;
    for (int i = 2; i <= 8; i++) begin tick(); cmp("pass rd_data0", 64'(bus.rd_data[5:0]), 64'(i)); end
    tick();
    cmp("last rd_data0", 64'(bus.rd_data[5:0]), 64'h2A);
    idle(); tick();

    // Threshold flags
    af_thresh = {4'd0, 4'd2};
    ae_thresh = {4'd0, 4'd1};
    wr(0, 6'h11); tick();
    cmp("ae at 1", 64'(almost_empty[0]), 64'h1);
    cmp("af at 1", 64'(almost_full[0]), 64'h0);
    for (int i = 0; i < 5; i++) begin wr(0, DW'(i)); tick(); end
    cmp("af at 6", 64'(almost_full[0]), 64'h1);
    cmp("ae at 6", 64'(almost_empty[0]), 64'h0);
    wr(0, 6'h22); tick(); wr(0, 6'h23); tick();
    cmp("af at 8", 64'(almost_full[0]), 64'h0);
    cmp("full at 8", 64'(full[0]), 64'h1);
    idle(); bus.rd_en = 2'b01;
    for (int i = 0; i < 8; i++) tick();
    idle(); tick();

    // Two channels, simultaneous reads, look-ahead head
    wr(0, 6'h05); tick();
    cmp("head0", 64'(bus.head_data[5:0]), 64'h05);
    wr(1, 6'h3F); tick();
    cmp("head both", 64'(bus.head_data), 64'({6'h3F, 6'h05}));
    idle(); bus.rd_en = 2'b11; tick();
    cmp("dual rd_data", 64'(bus.rd_data), 64'({6'h3F, 6'h05}));
    cmp("dual rd_valid", 64'(bus.rd_valid), 64'h3);
    idle(); tick();
    cmp("head empty", 64'(bus.head_data), 64'h0);

    // Underflow, error clear, init mid-stream
    bus.rd_en = 2'b10; tick();
    cmp("udf flag", 64'(udf_err), 64'h2);
    cmp("udf rd_valid", 64'(bus.rd_valid), 64'h0);
    cmp("udf rd_data hold", 64'(bus.rd_data[11:6]), 64'h3F);
    idle(); err_clr = 2'b10; tick(); idle();
    cmp("udf cleared", 64'(udf_err), 64'h0);
    for (int i = 0; i < 5; i++) begin wr(0, DW'(6'h10 + i)); tick(); end
    cmp("pre-init count0", 64'(count[3:0]), 64'h5);
    idle(); init = 1'b0; tick();
    cmp("init count0", 64'(count[3:0]), 64'h0);
    cmp("init head0", 64'(bus.head_data[5:0]), 64'h0);
    idle(); tick();

    // Randomized traffic alternating write-heavy and read-heavy phases
    for (int c = 0; c < 3000; c++) begin
      bit heavy_wr;
      heavy_wr = ((c / 48) % 2) == 0;
      bus.wr_en = $urandom_range(0, 99) < (heavy_wr ? 80 : 30);
      bus.wr_vc = 1'($urandom_range(0, 1));
      bus.wr_data = DW'($urandom);
      for (int v = 0; v < NV; v++) bus.rd_en[v] = $urandom_range(0, 99) < (heavy_wr ? 20 : 70);
      err_clr = ($urandom_range(0, 15) == 0) ? NV'($urandom_range(0, 3)) : '0;
      init = $urandom_range(0, 299) != 0;
      reset = $urandom_range(0, 499) != 0;
      if ($urandom_range(0, 63) == 0) begin
        af_thresh = (NV*CW)'($urandom);
        ae_thresh = (NV*CW)'($urandom);
      end
      tick();
    end
    idle(); reset = 1'b1; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vc_fifo_bank.md
Name: vc_fifo_bank

Overview:
Parametrised multi-virtual-channel FIFO bank for the PCIe transmit layer. It holds NUM_VC independent circular FIFOs behind one shared write port, which is steered by a VC index. Each channel has its own read port, its own programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Each channel also has a look-ahead head output that the downstream arbiter uses to decide what to push.

Parameters:
DATA_W, 6, payload width in bits
ADDR_W, 3, log2 of per-channel depth; DEPTH = 2**ADDR_W
NUM_VC, 2, number of virtual channels (>=1)
VC_W, 1, width of VC select; must equal max(1, clog2(NUM_VC))

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
init  in  1  synchronous active-low soft clear: same effect as reset except thresholds (inputs) untouched
wr_en  in  1  write strobe
wr_vc  in  VC_W  target channel of write
wr_data  in  DATA_W  write payload
rd_en  in  NUM_VC  per-channel read strobe
af_thresh  in  NUM_VC*(ADDR_W+1)  per-channel almost-full margin; channel v at slice [v*(ADDR_W+1) +: ADDR_W+1]
ae_thresh  in  NUM_VC*(ADDR_W+1)  per-channel almost-empty level, same slicing
err_clr  in  NUM_VC  per-channel error clear pulse
rd_data  out  NUM_VC*DATA_W  registered read data, slice v
rd_valid  out  NUM_VC  rd_data slice v valid this cycle
head_data  out  NUM_VC*DATA_W  combinational mem[rd_ptr] of channel v; 0 when empty
full, empty, almost_full, almost_empty  out  NUM_VC each  status flags
count  out  NUM_VC*(ADDR_W+1)  occupancy 0..DEPTH
ovf_err, udf_err  out  NUM_VC  sticky overflow/underflow errors

Behaviour:
- Reset or init low at clk edge: all wr_ptr/rd_ptr/count = 0; rd_data = 0; rd_valid = 0; ovf_err = udf_err = 0. Memory contents need not be cleared; head_data is forced to 0 by empty.
- After reset: empty = all 1s; full, almost_full = 0; almost_empty = 0.
- Count is ADDR_W+1 bits, so DEPTH is representable. Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- Write accepted when wr_en and (channel not full, or rd_en[wr_vc] accepted in the same cycle). Data goes to mem[wr_ptr] and wr_ptr increments.
- Write to a full channel with no same-cycle read: data dropped, pointers unchanged, ovf_err[wr_vc] set.
- wr_vc >= NUM_VC: write ignored, no error.
- Read accepted when rd_en[v] and channel v is not empty, judged on the pre-edge count. Next cycle: rd_data slice v = old head, rd_valid[v] = 1; rd_ptr increments. Latency is 1 cycle.
- rd_en[v] while empty: no pointer change, rd_valid[v] = 0, udf_err[v] set, rd_data slice v holds its previous value. There is no bypass: a same-cycle write into an empty channel is stored, but the read is still an underflow.
- Count update per channel: +1 on write only, -1 on read only, unchanged on both or neither.
- Reads on different channels in the same cycle are independent.
- Flags are combinational from the registered count (visible the cycle after the count update):
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count >= DEPTH-af_thresh) && !full
  - almost_empty = (count <= ae_thresh) && !empty
  - af_thresh > DEPTH saturates, meaning almost_full whenever not full.
- Errors are sticky. err_clr[v] clears them at the next edge; an error event in the same cycle wins over the clear.
- Reset or init asserted mid-transfer discards all data. Any rd_valid pending from that edge is suppressed.

Decomposition:
- Shared package holds DATA_W/ADDR_W/NUM_VC defaults, the DEPTH and count-width constants, and the slice-index helper.
- Sub-module vc_fifo_channel (single FIFO with count, flags, errors, read register) is instantiated NUM_VC times by a generate loop.
- The top level does write demux by wr_vc and packs/unpacks the vectors.

Test Plan:
1. Reset low 2 cycles, then high, DEPTH=8, NUM_VC=2 -> empty=2'b11, full=0, count=0, errors=0, rd_valid=0.
2. Write 0x01..0x08 to VC0 -> full[0]=1, count0=8; 9th write 0x09 -> ovf_err[0]=1, count0=8; reads return 0x01..0x08 in order, 1-cycle latency, then empty[0]=1.
3. VC0 full; write 0x2A with rd_en[0] in same cycle -> accepted, count0 stays 8, rd_data0=0x01; later last read returns 0x2A.
4. af_thresh0=2, ae_thresh0=1: writes to count 1 -> almost_empty=1; count 6 -> almost_full=1; count 8 -> almost_full=0, full=1.
5. Interleave writes VC0=0x05, VC1=0x3F, then rd_en=2'b11 -> rd_data0=0x05, rd_data1=0x3F same cycle; no cross-channel leakage; head_data tracks the head before each read.
6. rd_en[1] on empty VC1 -> udf_err[1]=1, rd_valid[1]=0; err_clr[1] -> cleared next cycle. init low mid-stream with count0=5 -> count0=0, head_data0=0.
